// File: rtl/bluetooth_tx.sv
// bluetooth_tx -- UART-style serial transmitter for the Bluetooth module link.
//
// Frame on tx: start bit (0), 8 data bits LSB first, optional even-parity bit,
// STOP_BITS stop bits (1). A one-byte holding register lets the producer queue
// the next byte while a frame is on the wire, so consecutive frames have no
// idle gap.
//
// Build option: define BLUETOOTH_TX_PARITY_EN to insert the even-parity cell
// between the last data bit and the stop bit(s). Undefined, parity logic and
// the PARITY state are compiled out.
//
// Ports:
//   clk               system clock, all logic on posedge
//   rst_in_n          asynchronous active-low reset
//   data_in[7:0]      byte to send
//   valid_in          data_in is valid
//   ready_out         block can accept a byte this cycle (= holding register empty)
//   tx                serial line, idles high
//   busy_out          a frame is in progress
//   finished_sending  one-cycle pulse in the final cycle of the last stop bit
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (0) on the line
// DATA   | data bits, shift[0] on the line, LSB first
// PARITY | even-parity bit captured at load time (BLUETOOTH_TX_PARITY_EN only)
// STOP   | STOP_BITS stop cells (1); reloads from hold or direct input at the end

module bluetooth_tx #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 115200,
    parameter int CYCLES_PER_BIT = CLK_FREQ / BAUD,
    parameter int STOP_BITS      = 1
) (
    input  logic       clk,
    input  logic       rst_in_n,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy_out,
    output logic       finished_sending
);

    localparam int BAUD_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

`ifdef BLUETOOTH_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              state, state_nxt;
    logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
    logic [2:0]          bit_cnt, bit_nxt;
    logic [7:0]          shift, shift_nxt;
    logic [7:0]          hold_data, hold_data_nxt;
    logic                hold_full, hold_full_nxt;
    logic                tx_nxt;
    logic                baud_done;
    logic                last_stop;
    logic                load_direct;
`ifdef BLUETOOTH_TX_PARITY_EN
    logic                par, par_nxt;
`endif

    assign baud_done        = (baud_cnt == BAUD_W'(CYCLES_PER_BIT - 1));
    // Multiple stop cells reuse the data bit counter to count cells.
    assign last_stop        = (bit_cnt == 3'(STOP_BITS - 1));
    assign finished_sending = (state == S_STOP) && baud_done && last_stop;
    assign ready_out        = !hold_full;
    assign busy_out         = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
`ifdef BLUETOOTH_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            hold_data <= hold_data_nxt;
            hold_full <= hold_full_nxt;
            tx        <= tx_nxt;
`ifdef BLUETOOTH_TX_PARITY_EN
            par       <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        baud_nxt      = baud_cnt;
        bit_nxt       = bit_cnt;
        shift_nxt     = shift;
        hold_data_nxt = hold_data;
        hold_full_nxt = hold_full;
        load_direct   = 1'b0;
`ifdef BLUETOOTH_TX_PARITY_EN
        par_nxt       = par;
`endif

        case (state)
            S_IDLE: begin
                load_direct = valid_in && !hold_full;
            end
            S_START: begin
                if (baud_done) begin
                    state_nxt = S_DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    baud_nxt  = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef BLUETOOTH_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
`ifdef BLUETOOTH_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    state_nxt = S_STOP;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    baud_nxt  = baud_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_nxt = '0;
                    if (last_stop) begin
                        bit_nxt = '0;
                        if (hold_full) begin
                            // Held byte goes straight out: no idle cycle between frames.
                            state_nxt     = S_START;
                            shift_nxt     = hold_data;
                            hold_full_nxt = 1'b0;
`ifdef BLUETOOTH_TX_PARITY_EN
                            par_nxt       = ^hold_data;
`endif
                        end else if (valid_in) begin
                            load_direct = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A byte arriving while the shifter is free starts a frame directly;
        // otherwise it parks in the holding register.
        if (load_direct) begin
            state_nxt = S_START;
            shift_nxt = data_in;
            baud_nxt  = '0;
            bit_nxt   = '0;
`ifdef BLUETOOTH_TX_PARITY_EN
            par_nxt   = ^data_in;
`endif
        end else if (valid_in && !hold_full && (state != S_IDLE)) begin
            hold_data_nxt = data_in;
            hold_full_nxt = 1'b1;
        end

        // tx is registered from the next-state values so the line is glitch-free
        // and still falls in the cycle right after an accepting edge.
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shift_nxt[0];
`ifdef BLUETOOTH_TX_PARITY_EN
            S_PARITY: tx_nxt = par_nxt;
`endif
            default:  tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bluetooth_tx.sv
// Testbench for bluetooth_tx. A bench-side line receiver decodes frames from tx
// at mid-bit and compares them against bytes queued at each accepting edge.
// Works with or without BLUETOOTH_TX_PARITY_EN.

module tb_bluetooth_tx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;   // 16 cycles per bit
`ifdef BLUETOOTH_TX_PARITY_EN
    localparam int N_BITS   = 11;
`else
    localparam int N_BITS   = 10;
`endif
    localparam int FRAME    = N_BITS * CPB;
    localparam int BOUND    = 4000;

    logic       clk;
    logic       rst_in_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx;
    logic       busy_out;
    logic       finished_sending;

    bluetooth_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .STOP_BITS(1)
    ) dut (
        .clk             (clk),
        .rst_in_n        (rst_in_n),
        .data_in         (data_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .tx              (tx),
        .busy_out        (busy_out),
        .finished_sending(finished_sending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       start_ok;
        logic       stop;
        int         start;
    } frame_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         last_acc_cyc = 0;
    int         tx_fall_cnt = 0;
    logic [7:0] exp_q[$];
    frame_t     rx_q[$];
    int         fin_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard input: every accepting edge queues the byte that must appear.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_in_n && valid_in && ready_out) begin
                exp_q.push_back(data_in);
                acc_cnt++;
                last_acc_cyc = cyc + 1;
            end
        end
    end

    // Line receiver: sample each cell at its midpoint.
    initial begin
        bit     mon_active;
        int     mstart;
        int     mk;
        frame_t fr;
        mon_active = 0;
        mstart = 0;
        mk = 0;
        fr = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_in_n) begin
                mon_active = 0;
            end else begin
                if (finished_sending === 1'b1) fin_q.push_back(cyc);
                if (!mon_active) begin
                    if (tx === 1'b0) begin
                        mon_active = 1;
                        mstart = cyc;
                        mk = 0;
                        tx_fall_cnt++;
                    end
                end else if (cyc == mstart + mk * CPB + CPB / 2) begin
                    if (mk == 0) fr.start_ok = (tx === 1'b0);
                    else if (mk == N_BITS - 1) begin
                        fr.stop  = tx;
                        fr.start = mstart;
                        rx_q.push_back(fr);
                        mon_active = 0;
                    end
                    else if (mk <= 8) fr.data[3'(mk - 1)] = tx;
                    else fr.par = tx;
                    mk++;
                end
            end
        end
    end

    // Drive one byte from a negedge and wait for it to be accepted.
    task automatic drive_byte(input logic [7:0] b, input bit keep);
        int base;
        base = acc_cnt;
        data_in = b;
        valid_in = 1'b1;
        for (int i = 0; i < BOUND && acc_cnt == base; i++) @(negedge clk);
        checks++;
        if (acc_cnt == base) begin
            errors++;
            $display("FAIL accept_timeout byte %h: no accept, required accept", b);
        end
        if (!keep) valid_in = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < BOUND && rx_q.size() < n; i++) @(negedge clk);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (rx_q.size() < n) begin
            errors++;
            $display("FAIL frame_timeout got %0d frames, required %0d", rx_q.size(), n);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        rx_q.delete();
        fin_q.delete();
    endtask

    // Compare one decoded frame against the next scoreboard entry.
    task automatic check_frame(input string tag, input int exp_start);
        frame_t     f;
        logic [7:0] e;
        if (rx_q.size() == 0 || exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_missing rx %0d exp %0d entries", tag, rx_q.size(), exp_q.size());
            return;
        end
        f = rx_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (f.data !== e) begin
            errors++;
            $display("FAIL %s_data got %h required %h", tag, f.data, e);
        end
        checks++;
        if (f.start_ok !== 1'b1 || f.stop !== 1'b1) begin
            errors++;
            $display("FAIL %s_framing start_ok %b stop %b required 1 1", tag, f.start_ok, f.stop);
        end
`ifdef BLUETOOTH_TX_PARITY_EN
        checks++;
        if (f.par !== ^e) begin
            errors++;
            $display("FAIL %s_parity got %b required %b", tag, f.par, ^e);
        end
`endif
        if (exp_start >= 0) begin
            checks++;
            if (f.start !== exp_start) begin
                errors++;
                $display("FAIL %s_start_cycle got %0d required %0d", tag, f.start, exp_start);
            end
        end
    endtask

    task automatic test_reset();
        rst_in_n = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || ready_out !== 1'b1 || busy_out !== 1'b0 || finished_sending !== 1'b0) begin
            errors++;
            $display("FAIL reset_values tx %b ready %b busy %b fin %b required 1 1 0 0",
                     tx, ready_out, busy_out, finished_sending);
        end
        rst_in_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset tx %b busy %b required 1 0", tx, busy_out);
        end
    endtask

    task automatic test_single();
        int  acc;
        bit  line_bad;
        clear_sb();
        drive_byte(8'hAB, 1'b0);
        acc = last_acc_cyc;
        wait_frames(1);
        line_bad = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy_out !== 1'b0) line_bad = 1;
        end
        checks++;
        if (fin_q.size() != 1) begin
            errors++;
            $display("FAIL single_fin_count got %0d required 1", fin_q.size());
        end else begin
            checks++;
            if (fin_q[0] != acc + FRAME - 1) begin
                errors++;
                $display("FAIL single_fin_cycle got %0d required %0d", fin_q[0] - acc, FRAME - 1);
            end
        end
        check_frame("single", acc);
        checks++;
        if (line_bad) begin
            errors++;
            $display("FAIL single_idle_line tx/busy left idle, required tx 1 busy 0");
        end
    endtask

    task automatic test_back_to_back();
        int  a1;
        int  fin0;
        bit  rdy_bad;
        bit  seen;
        clear_sb();
        drive_byte(8'hAB, 1'b1);
        a1 = last_acc_cyc;
        drive_byte(8'h55, 1'b0);
        rdy_bad = 0;
        seen = 0;
        fin0 = 0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            if (ready_out !== 1'b0) rdy_bad = 1;
            if (finished_sending === 1'b1) begin
                seen = 1;
                fin0 = cyc;
            end else @(negedge clk);
        end
        checks++;
        if (rdy_bad || !seen) begin
            errors++;
            $display("FAIL b2b_ready_low ready rose early or no finish (seen %b), required ready 0 until finish", seen);
        end
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_rise got %b required 1", ready_out);
        end
        wait_frames(2);
        check_frame("b2b_first", a1);
        check_frame("b2b_second", a1 + FRAME);
        checks++;
        if (fin_q.size() != 2 || fin0 != a1 + FRAME - 1) begin
            errors++;
            $display("FAIL b2b_fin fins %0d first at %0d required 2 at %0d", fin_q.size(), fin0, a1 + FRAME - 1);
        end
    endtask

    task automatic test_hold_full();
        int  a1;
        int  base;
        int  fin0;
        bit  seen;
        bit  bad;
        clear_sb();
        drive_byte(8'hAB, 1'b1);
        a1 = last_acc_cyc;
        drive_byte(8'h55, 1'b1);
        data_in = 8'h3C;
        base = acc_cnt;
        bad = 0;
        seen = 0;
        fin0 = 0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            @(negedge clk);
            if (finished_sending === 1'b1) begin
                seen = 1;
                fin0 = cyc;
            end
            if (ready_out !== 1'b0 || acc_cnt != base) bad = 1;
        end
        checks++;
        if (bad || !seen) begin
            errors++;
            $display("FAIL full_refuse ready %b accepts %0d required 0 and %0d", ready_out, acc_cnt, base);
        end
        drive_byte(8'h3C, 1'b0);
        checks++;
        if (last_acc_cyc != fin0 + 2) begin
            errors++;
            $display("FAIL full_late_accept at %0d required %0d", last_acc_cyc, fin0 + 2);
        end
        wait_frames(3);
        check_frame("full_1", a1);
        check_frame("full_2", a1 + FRAME);
        check_frame("full_3", a1 + 2 * FRAME);
    endtask

    task automatic test_reset_mid_frame();
        int a1;
        int falls;
        clear_sb();
        drive_byte(8'hAB, 1'b0);
        a1 = last_acc_cyc;
        drive_byte(8'h55, 1'b0);
        // 0xAB data bit 2 is 0 -> the line is low during cell 3.
        for (int i = 0; i < BOUND && cyc < a1 + 3 * CPB + 4; i++) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre tx %b ready %b required 0 0", tx, ready_out);
        end
        @(posedge clk);
        #1 rst_in_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || ready_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async tx %b ready %b busy %b required 1 1 0", tx, ready_out, busy_out);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_in_n = 1'b1;
        falls = tx_fall_cnt;
        fin_q.delete();
        repeat (3 * FRAME) @(negedge clk);
        checks++;
        if (tx_fall_cnt != falls || fin_q.size() != 0 || busy_out !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet falls %0d fins %0d busy %b tx %b required 0 0 0 1",
                     tx_fall_cnt - falls, fin_q.size(), busy_out, tx);
        end
        exp_q.delete();
    endtask

    task automatic test_loopback();
        logic [7:0] pat [3];
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'hA5;
        clear_sb();
        for (int i = 0; i < 3; i++) drive_byte(pat[i], 1'b0);
        wait_frames(3);
        checks++;
        if (fin_q.size() != 3) begin
            errors++;
            $display("FAIL loop_fin_count got %0d required 3", fin_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_q.size() > i && rx_q[i].data !== pat[i]) begin
                errors++;
                $display("FAIL loop_byte%0d got %h required %h", i, rx_q[i].data, pat[i]);
            end
        end
        for (int i = 0; i < 3; i++) check_frame("loop", -1);
    endtask

    initial begin
        rst_in_n = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_full();
        test_reset_mid_frame();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
